// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the execute stage and a handshaked data memory.
// Stores are posted into an in-order FIFO store buffer and retire immediately.
// Loads wait for the buffer to drain, so memory never sees a load ahead of an
// older store, and then perform a single read.
module dmem_lsu #(
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_trap,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [3:0]        o_mem_mask,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic              i_mem_valid,
  input  logic [31:0]       i_mem_rdata
);

  localparam int PW = $clog2(SB_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DRAIN   = 2'd1;
  localparam logic [1:0] S_RD_REQ  = 2'd2;
  localparam logic [1:0] S_RD_WAIT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PW:0]       wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [3:0]        sb_mask_q [SB_DEPTH];
  logic [31:0]       sb_data_q [SB_DEPTH];

  logic [ADDR_W-1:0] ld_addr_q;
  logic [3:0]        ld_mask_q;
  logic [1:0]        ld_off_q;
  logic [2:0]        ld_funct3_q;

  logic              rsp_valid_q, rsp_trap_q;
  logic [31:0]       rsp_rdata_q;

  // Request decode
  logic [1:0]        req_off;
  logic [ADDR_W-1:0] req_addr_aligned;
  logic              f3_ok, align_ok, req_legal;
  logic [3:0]        req_mask;
  logic [31:0]       req_wdata_sh;

  assign req_off          = i_req_addr[1:0];
  assign req_addr_aligned = {i_req_addr[ADDR_W-1:2], 2'b00};
  assign req_wdata_sh     = i_req_wdata << {req_off, 3'b000};

  // Legality, alignment and byte-lane mask for the incoming request
  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b0;
    req_mask = 4'b1111;
    if (i_req_wen) f3_ok = (i_req_funct3 <= 3'd2);
    else           f3_ok = (i_req_funct3 != 3'd3) && (i_req_funct3 <= 3'd5);
    case (i_req_funct3[1:0])
      2'd0: begin align_ok = 1'b1;              req_mask = 4'b0001 << req_off; end
      2'd1: begin align_ok = !req_off[0];       req_mask = 4'b0011 << req_off; end
      2'd2: begin align_ok = (req_off == 2'd0); req_mask = 4'b1111;            end
      default: begin align_ok = 1'b0;           req_mask = 4'b1111;            end
    endcase
  end

  assign req_legal = f3_ok && align_ok;

  // Store buffer status; count is the pointer difference, which wraps correctly
  logic          sb_empty, sb_full, sb_pop, sb_push, sb_left;
  logic [PW:0]   sb_count;
  logic [PW-1:0] wr_idx, rd_idx;
  logic          accept, ld_go;

  assign wr_idx   = wr_ptr_q[PW-1:0];
  assign rd_idx   = rd_ptr_q[PW-1:0];
  assign sb_empty = (wr_ptr_q == rd_ptr_q);
  assign sb_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
  assign sb_count = wr_ptr_q - rd_ptr_q;

  // Reset gates the handshakes so nothing is accepted or issued while it is held
  assign o_req_ready = (state_q == S_IDLE) && !sb_full && !i_rst;
  assign o_mem_ren   = (state_q == S_RD_REQ) && !i_rst;
  assign o_mem_wen   = !sb_empty && ((state_q == S_IDLE) || (state_q == S_DRAIN)) && !i_rst;
  assign o_mem_addr  = o_mem_ren ? ld_addr_q : sb_addr_q[rd_idx];
  assign o_mem_mask  = o_mem_ren ? ld_mask_q : sb_mask_q[rd_idx];
  assign o_mem_wdata = sb_data_q[rd_idx];

  assign accept  = i_req_valid && o_req_ready;
  assign sb_push = accept && i_req_wen && req_legal;
  assign ld_go   = accept && !i_req_wen && req_legal;
  assign sb_pop  = o_mem_wen && i_mem_ready;
  // Entries still buffered after this cycle's pop (a load accept never pushes)
  assign sb_left = (sb_count != {{PW{1'b0}}, sb_pop});

  // Next-state logic: loads wait in DRAIN until every older store is written
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (ld_go) state_d = sb_left ? S_DRAIN : S_RD_REQ;
      S_DRAIN:   if (!sb_left) state_d = S_RD_REQ;
      S_RD_REQ:  if (i_mem_ready) state_d = S_RD_WAIT;
      S_RD_WAIT: if (i_mem_valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Load data: move the addressed lane to bit 0, truncate, then extend
  logic [31:0] ld_shifted, ld_result;
  assign ld_shifted = i_mem_rdata >> {ld_off_q, 3'b000};

  // Size and sign selection for the returned load value
  always_comb begin
    ld_result = ld_shifted;
    case (ld_funct3_q)
      3'd0:    ld_result = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'd1:    ld_result = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'd4:    ld_result = {24'd0, ld_shifted[7:0]};
      3'd5:    ld_result = {16'd0, ld_shifted[15:0]};
      default: ld_result = ld_shifted;
    endcase
  end

  // FSM, pointers and registered response; reset drops buffer and pending read
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_trap_q  <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;
      rsp_trap_q  <= 1'b0;
      rsp_rdata_q <= 32'd0;
      if (sb_push) wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, 1'b1};
      if (sb_pop)  rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, 1'b1};
      if (accept && (i_req_wen || !req_legal)) begin
        rsp_valid_q <= 1'b1;
        rsp_trap_q  <= !req_legal;
      end else if ((state_q == S_RD_WAIT) && i_mem_valid) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= ld_result;
      end
    end
  end

  // Store buffer storage and load request capture; contents need no reset
  always_ff @(posedge i_clk) begin
    if (sb_push) begin
      sb_addr_q[wr_idx] <= req_addr_aligned;
      sb_mask_q[wr_idx] <= req_mask;
      sb_data_q[wr_idx] <= req_wdata_sh;
    end
    if (ld_go) begin
      ld_addr_q   <= req_addr_aligned;
      ld_mask_q   <= req_mask;
      ld_off_q    <= req_off;
      ld_funct3_q <= i_req_funct3;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_trap  = rsp_trap_q;
  assign o_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized and directed stimulus for dmem_lsu. A byte-level
// reference memory predicts every response, write and read; a memory device
// model drives the handshake; a monitor pops expected responses in order.
module tb_dmem_lsu;
  localparam int ADDR_W   = 32;
  localparam int SB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0, i_req_wen = 1'b0;
  logic [2:0]  i_req_funct3 = 3'd0;
  logic [31:0] i_req_addr = 32'd0, i_req_wdata = 32'd0;
  logic        o_req_ready, o_rsp_valid, o_rsp_trap;
  logic [31:0] o_rsp_rdata;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        o_mem_ren, o_mem_wen;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready = 1'b0, i_mem_valid = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
    .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_trap(o_rsp_trap),
    .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
    .o_mem_mask(o_mem_mask), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] rdata; logic trap; } rsp_t;
  typedef struct packed { logic [31:0] addr; logic [3:0] mask; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] addr; logic [3:0] mask; } rd_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rd_t  rd_q[$];

  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] dev_mem [int unsigned];

  function automatic logic [31:0] init_word(input int unsigned waddr);
    return (waddr * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [7:0] ref_byte(input int unsigned a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a >> 2);
    return w[8*(a%4) +: 8];
  endfunction

  function automatic logic [31:0] dev_word(input int unsigned waddr);
    if (dev_mem.exists(waddr)) return dev_mem[waddr];
    return init_word(waddr);
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    dev_mem[a >> 2] = v;
    for (int i = 0; i < 4; i++) ref_mem[a + i] = v[8*i +: 8];
  endtask

  // Predict the outcome of a request the DUT is accepting at the next edge
  task automatic model_accept(input bit wen, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
    int   sz, off;
    bit   ok;
    rsp_t r;
    wr_t  w;
    rd_t  rq;
    longint v;
    sz  = 1 << f3[1:0];
    off = int'(a[1:0]);
    ok  = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ok  = ok && ((off % sz) == 0);
    r.rdata = 32'd0;
    r.trap  = !ok;
    if (ok && wen) begin
      w.addr = a & 32'hFFFF_FFFC;
      w.mask = 4'd0;
      w.data = 32'd0;
      for (int i = 0; i < sz; i++) begin
        w.mask[off + i]          = 1'b1;
        w.data[8*(off + i) +: 8] = wd[8*i +: 8];
        ref_mem[a + i]           = wd[8*i +: 8];
      end
      wr_q.push_back(w);
    end else if (ok) begin
      v = 0;
      rq.addr = a & 32'hFFFF_FFFC;
      rq.mask = 4'd0;
      for (int i = 0; i < sz; i++) begin
        v = v | (longint'(ref_byte(a + i)) << (8*i));
        rq.mask[off + i] = 1'b1;
      end
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8*sz));
      r.rdata = v[31:0];
      rd_q.push_back(rq);
    end
    rsp_q.push_back(r);
  endtask

  // ---------------- memory device ----------------
  int          dev_ready_mode = 1;  // 0: ready low, 1: ready high, 2: random
  int          dev_lat_fixed  = 0;  // 0: random read latency 1..4
  bit          rd_pend = 1'b0;
  int          rd_wait = 0;
  logic [31:0] rd_word = 32'd0;

  // Drive memory handshake at the falling edge; evaluate the upcoming transfer 1ns later
  always @(negedge clk) begin
    wr_t  w;
    rd_t  rq;
    logic [31:0] m;
    i_mem_valid = 1'b0;
    i_mem_rdata = 32'd0;
    if (rd_pend) begin
      if (rd_wait <= 1) begin
        i_mem_valid = 1'b1;
        i_mem_rdata = rd_word;
        rd_pend     = 1'b0;
      end else begin
        rd_wait--;
      end
    end
    i_mem_ready = (dev_ready_mode == 2) ? 1'($urandom_range(0, 1)) : (dev_ready_mode == 1);
    #1;
    if (!rst) begin
      if (o_mem_ren && o_mem_wen) fail_now("ren_wen_both", "ren and wen both high");
      if (o_mem_ren && i_mem_ready) begin
        if (rd_q.size() == 0) fail_now("read_unexpected", $sformatf("read at %h, no load expected", o_mem_addr));
        else begin
          rq = rd_q.pop_front();
          chk("read_addr", o_mem_addr, rq.addr);
          chk("read_mask", {28'd0, o_mem_mask}, {28'd0, rq.mask});
          chk("read_after_stores", wr_q.size(), 0);
          rd_word = dev_word(rq.addr >> 2);
          rd_pend = 1'b1;
          rd_wait = (dev_lat_fixed != 0) ? dev_lat_fixed : int'($urandom_range(1, 4));
        end
      end
      if (o_mem_wen && i_mem_ready) begin
        if (wr_q.size() == 0) fail_now("write_unexpected", $sformatf("write at %h, no store expected", o_mem_addr));
        else begin
          w = wr_q.pop_front();
          m = {{8{w.mask[3]}}, {8{w.mask[2]}}, {8{w.mask[1]}}, {8{w.mask[0]}}};
          chk("write_addr", o_mem_addr, w.addr);
          chk("write_mask", {28'd0, o_mem_mask}, {28'd0, w.mask});
          chk("write_data", o_mem_wdata & m, w.data & m);
          dev_mem[w.addr >> 2] = (dev_word(w.addr >> 2) & ~m) | (o_mem_wdata & m);
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    rsp_t r;
    if (!rst && o_rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0)
        fail_now("rsp_unexpected", $sformatf("rdata %h trap %0b, expected no response", o_rsp_rdata, o_rsp_trap));
      else begin
        r = rsp_q.pop_front();
        chk("rsp_rdata", o_rsp_rdata, r.rdata);
        chk("rsp_trap", {31'd0, o_rsp_trap}, {31'd0, r.trap});
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; returns at the falling edge after the accepting edge
  task automatic issue(input bit wen, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    bit to;
    n  = 0;
    to = 1'b0;
    i_req_valid = 1'b1; i_req_wen = wen; i_req_funct3 = f3; i_req_addr = a; i_req_wdata = wd;
    #1;
    while (o_req_ready !== 1'b1) begin
      if (n >= 300) begin to = 1'b1; break; end
      n++;
      @(negedge clk); #1;
    end
    if (to) fail_now("req_timeout", $sformatf("ready stayed %b, required 1", o_req_ready));
    else model_accept(wen, f3, a, wd);
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  // Reconfigure the device away from the falling edge it acts on
  task automatic cfg(input int mode, input int lat);
    @(posedge clk); #1;
    dev_ready_mode = mode;
    dev_lat_fixed  = lat;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (wr_q.size() != 0 || rd_q.size() != 0 || rsp_q.size() != 0 || o_req_ready !== 1'b1) begin
      if (n >= 1000) begin
        fail_now("drain_timeout", $sformatf("wr %0d rd %0d rsp %0d pending, required 0", wr_q.size(), rd_q.size(), rsp_q.size()));
        break;
      end
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit got, seen;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'd0, o_req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("reset_rsp_trap", {31'd0, o_rsp_trap}, 32'd0);
    chk("reset_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("reset_mem_ren", {31'd0, o_mem_ren}, 32'd0);
    chk("reset_mem_wen", {31'd0, o_mem_wen}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("ready_after_reset", {31'd0, o_req_ready}, 32'd1);
    @(negedge clk);

    // lbu / lb at 0x1003 with minimum latency
    set_word(32'h1000, 32'hAABBCCDD);
    cfg(1, 1);
    issue(1'b0, 3'd4, 32'h1003, 32'd0);
    @(negedge clk);
    chk("ready_during_load", {31'd0, o_req_ready}, 32'd0);
    @(negedge clk);
    chk("lbu_latency_valid", {31'd0, o_rsp_valid}, 32'd1);
    chk("lbu_value", o_rsp_rdata, 32'h000000AA);
    wait_drain();
    issue(1'b0, 3'd0, 32'h1003, 32'd0);
    repeat (2) @(negedge clk);
    chk("lb_value", o_rsp_rdata, 32'hFFFFFFAA);
    wait_drain();

    // sh to 0x2002
    issue(1'b1, 3'd1, 32'h2002, 32'h0000_1234);
    chk("sh_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
    chk("sh_rsp_trap", {31'd0, o_rsp_trap}, 32'd0);
    wait_drain();

    // Misaligned word accesses trap without memory traffic
    issue(1'b0, 3'd2, 32'h1001, 32'd0);
    chk("lw_mis_trap", {31'd0, o_rsp_valid & o_rsp_trap}, 32'd1);
    chk("lw_mis_rdata", o_rsp_rdata, 32'd0);
    issue(1'b1, 3'd2, 32'h1002, 32'hDEADBEEF);
    chk("sw_mis_trap", {31'd0, o_rsp_valid & o_rsp_trap}, 32'd1);
    wait_drain();

    // Fill the buffer with memory stalled, then drain and load behind it
    cfg(0, 0);
    for (int i = 0; i < SB_DEPTH; i++) issue(1'b1, 3'd2, 32'h4000 + 4*i, $urandom);
    #1;
    chk("sb_full_ready", {31'd0, o_req_ready}, 32'd0);
    @(posedge clk); #1;
    dev_ready_mode = 1;
    @(negedge clk); #2;
    chk("full_on_pop_ready", {31'd0, o_req_ready}, 32'd0);
    issue(1'b0, 3'd2, 32'h4000 + 4*(SB_DEPTH-1), 32'd0);
    wait_drain();

    // lhu with a 5-cycle read latency; response exactly one cycle after valid
    set_word(32'h3000, 32'h80015A5A);
    cfg(1, 5);
    issue(1'b0, 3'd5, 32'h3002, 32'd0);
    got = 1'b0; seen = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk); #2;
      if (seen) begin
        chk("lhu_rsp_after_valid", {31'd0, o_rsp_valid}, 32'd1);
        chk("lhu_value", o_rsp_rdata, 32'h00008001);
        got = 1'b1;
      end else begin
        chk("lhu_ready_low", {31'd0, o_req_ready}, 32'd0);
        chk("lhu_no_early_rsp", {31'd0, o_rsp_valid}, 32'd0);
        seen = i_mem_valid;
      end
    end
    if (!got) fail_now("lhu_timeout", "no read data within 20 cycles");
    wait_drain();

    // Reset while waiting for read data; the late data must be ignored
    cfg(1, 8);
    issue(1'b0, 3'd2, 32'h1000, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rsp_q.delete(); wr_q.delete(); rd_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_read_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_mid_read_wen", {31'd0, o_mem_wen}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #2;
      chk("stray_valid_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    end

    // Randomized mix including illegal funct3 and misaligned addresses
    cfg(2, 0);
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = 32'h1000 + ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 1) == 0) a = a + 32'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_drain();
    chk("final_rsp_queue", rsp_q.size(), 0);
    chk("final_write_queue", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

endmodule
